// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and
// lock synchroniser depth.
package rst_seq_pkg;

  localparam int SYNC_DEPTH = 2;

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_DONE      = 3'd3,
    ST_FAULT     = 3'd4
  } seq_state_e;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser for a single asynchronous bit, with a synchronous
// active-low clear that empties the whole chain.
module bit_synchronizer
  import rst_seq_pkg::*;
(
  input  logic iclk,
  input  logic irst_n,
  input  logic async_in,
  output logic sync_out
);

  logic [SYNC_DEPTH-1:0] sync_pipe;

  // Shift the async bit through the chain; clear forces every flop low.
  always_ff @(posedge iclk) begin
    if (!irst_n) sync_pipe <= '0;
    else         sync_pipe <= {sync_pipe[SYNC_DEPTH-2:0], async_in};
  end

  assign sync_out = sync_pipe[SYNC_DEPTH-1];

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: waits for clock-generator lock, then releases NUM_STAGES
// active-low resets in order, STAGE_DELAY cycles apart. Flags a fault if
// lock does not arrive within LOCK_TIMEOUT cycles.
// Optional build macro RSTSEQ_AUTO_RETRY_EN: Fault times out (or sees lock)
// and returns to WaitLock instead of holding until reset.
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES   = 4,
  parameter int STAGE_DELAY  = 16,
  parameter int LOCK_TIMEOUT = 200,
  parameter int CNT_W        = 8
)(
  input  logic                  iclk,
  input  logic                  irst_n,
  input  logic                  ilock,
  output logic [NUM_STAGES-1:0] orst_n,
  output logic                  odone,
  output logic                  otimeout
);

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STAGES - 1);

  seq_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_STAGES-1:0] rst_q, rst_d;
  logic                  done_q, done_d;
  logic                  tmo_q, tmo_d;
  logic                  lock_s;

  bit_synchronizer u_lock_sync (
    .iclk     (iclk),
    .irst_n   (irst_n),
    .async_in (ilock),
    .sync_out (lock_s)
  );

  // State, counters and output registers; reset wins over everything.
  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    done_d  = done_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      ST_HOLD: begin
        state_d = ST_WAIT_LOCK;
        cnt_d   = '0;
      end
      ST_WAIT_LOCK: begin
        // Lock beats a timeout landing on the same cycle.
        if (lock_s) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (cnt_q == TMO_LAST) begin
          state_d = ST_FAULT;
          cnt_d   = '0;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (!lock_s) begin
          // Lock lost: re-assert every stage together, start a new window.
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
          idx_d   = '0;
          rst_d   = '0;
          done_d  = 1'b0;
        end else if (cnt_q == DLY_LAST) begin
          rst_d[idx_q] = 1'b1;
          cnt_d        = '0;
          idx_d        = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
          idx_d   = '0;
          rst_d   = '0;
          done_d  = 1'b0;
        end
      end
      ST_FAULT: begin
`ifdef RSTSEQ_AUTO_RETRY_EN
        // Retry after a full timeout period, or at once if lock shows up.
        if (lock_s || (cnt_q == TMO_LAST)) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
          tmo_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`else
        // Terminal until the board reset is re-applied.
        state_d = ST_FAULT;
`endif
      end
      default: begin
        state_d = ST_HOLD;
        cnt_d   = '0;
        idx_d   = '0;
        rst_d   = '0;
        done_d  = 1'b0;
        tmo_d   = 1'b0;
      end
    endcase
  end

  assign orst_n   = rst_q;
  assign odone    = done_q;
  assign otimeout = tmo_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios with literal expectations,
// then random reset/lock activity checked every cycle against a timestamp
// model of the sequencer.
module tb_reset_sequencer;

  localparam int NS = 4;
  localparam int SD = 16;
  localparam int LT = 200;

  localparam int M_HOLD  = 0;
  localparam int M_WAIT  = 1;
  localparam int M_REL   = 2;
  localparam int M_FAULT = 3;

  logic          iclk = 1'b0;
  logic          irst_n;
  logic          ilock;
  logic [NS-1:0] orst_n;
  logic          odone;
  logic          otimeout;

  int checks = 0;
  int fails  = 0;

  // model state: lock history, current phase, edge count of phase entry
  int m_cyc   = 0;
  int m_mode  = M_HOLD;
  int m_t0    = 0;
  bit m_s1    = 1'b0;
  bit m_s2    = 1'b0;
  bit m_valid = 1'b0;
  int e_rst, e_done, e_tmo;

  reset_sequencer #(
    .NUM_STAGES   (NS),
    .STAGE_DELAY  (SD),
    .LOCK_TIMEOUT (LT),
    .CNT_W        (8)
  ) dut (
    .iclk     (iclk),
    .irst_n   (irst_n),
    .ilock    (ilock),
    .orst_n   (orst_n),
    .odone    (odone),
    .otimeout (otimeout)
  );

  always #5 iclk = ~iclk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge iclk);
  endtask

  // Advance the model by one rising edge using the inputs present at it.
  task automatic model_step();
    bit lk;
    int n;
    m_cyc++;
    if (!irst_n) begin
      m_mode  = M_HOLD;
      m_s1    = 1'b0;
      m_s2    = 1'b0;
      m_valid = 1'b1;
    end else begin
      lk   = m_s2;
      m_s2 = m_s1;
      m_s1 = ilock;
      case (m_mode)
        M_HOLD: begin m_mode = M_WAIT; m_t0 = m_cyc; end
        M_WAIT: begin
          if (lk)                     begin m_mode = M_REL;   m_t0 = m_cyc; end
          else if (m_cyc - m_t0 == LT) begin m_mode = M_FAULT; m_t0 = m_cyc; end
        end
        M_REL: if (!lk) begin m_mode = M_WAIT; m_t0 = m_cyc; end
        default: begin
`ifdef RSTSEQ_AUTO_RETRY_EN
          if (lk || (m_cyc - m_t0 == LT)) begin m_mode = M_WAIT; m_t0 = m_cyc; end
`endif
        end
      endcase
    end
    e_rst = 0; e_done = 0; e_tmo = 0;
    if (m_mode == M_REL) begin
      n = (m_cyc - m_t0) / SD;
      if (n > NS) n = NS;
      e_rst  = (1 << n) - 1;
      e_done = (n == NS) ? 1 : 0;
    end
    if (m_mode == M_FAULT) e_tmo = 1;
  endtask

  // Per-cycle comparison against the model, 1 time unit after each edge.
  initial begin
    forever begin
      @(posedge iclk);
      model_step();
      #1;
      if (m_valid) begin
        chk("model_orst_n", int'(orst_n), e_rst);
        chk("model_odone", int'(odone), e_done);
        chk("model_otimeout", int'(otimeout), e_tmo);
      end
    end
  end

  initial begin
    irst_n = 1'b0;
    ilock  = 1'b1;

    // power-up with lock already present
    tick(5);
    chk("reset_orst_n", int'(orst_n), 0);
    chk("reset_odone", int'(odone), 0);
    chk("reset_otimeout", int'(otimeout), 0);
    irst_n = 1'b1;
    tick(18); chk("pre_stage0", int'(orst_n), 4'b0000);
    tick(1);  chk("stage0", int'(orst_n), 4'b0001);
    tick(16); chk("stage1", int'(orst_n), 4'b0011);
    tick(16); chk("stage2", int'(orst_n), 4'b0111);
    tick(15); chk("done_early", int'(odone), 0);
    tick(1);  chk("stage3", int'(orst_n), 4'b1111);
    chk("done_set", int'(odone), 1);

    // lock loss in Done, then relock
    tick(5);
    ilock = 1'b0;
    tick(2); chk("loss_hold", int'(orst_n), 4'b1111);
    tick(1); chk("loss_orst_n", int'(orst_n), 4'b0000);
    chk("loss_odone", int'(odone), 0);
    ilock = 1'b1;
    tick(18); chk("relock_pre", int'(orst_n), 4'b0000);
    tick(1);  chk("relock_s0", int'(orst_n), 4'b0001);
    tick(16); chk("relock_s1", int'(orst_n), 4'b0011);

    // reset mid-sequence
    irst_n = 1'b0;
    tick(1);
    chk("midrst_orst_n", int'(orst_n), 0);
    chk("midrst_odone", int'(odone), 0);
    chk("midrst_otimeout", int'(otimeout), 0);

    // lock never arrives
    ilock = 1'b0;
    tick(3);
    irst_n = 1'b1;
    tick(200); chk("tmo_early", int'(otimeout), 0);
    tick(1);   chk("tmo_set", int'(otimeout), 1);
    chk("tmo_orst_n", int'(orst_n), 0);
    chk("tmo_odone", int'(odone), 0);
`ifdef RSTSEQ_AUTO_RETRY_EN
    tick(199); chk("retry_hold", int'(otimeout), 1);
    tick(1);   chk("retry_clear", int'(otimeout), 0);
    ilock = 1'b1;
    tick(100);
    chk("retry_done", int'(odone), 1);
    chk("retry_orst_n", int'(orst_n), 4'b1111);
`else
    tick(300); chk("fault_sticky", int'(otimeout), 1);
    ilock = 1'b1;
    tick(100);
    chk("fault_lock_ign", int'(otimeout), 1);
    chk("fault_orst_n", int'(orst_n), 0);
`endif

    // lock arrives on the very cycle the timeout would fire
    irst_n = 1'b0;
    ilock  = 1'b0;
    tick(3);
    irst_n = 1'b1;
    tick(198);
    ilock = 1'b1;
    tick(2);  chk("race_pre", int'(otimeout), 0);
    tick(1);  chk("race_tmo", int'(otimeout), 0);
    tick(16); chk("race_s0", int'(orst_n), 4'b0001);

    // random reset pulses and lock flicker
    for (int i = 0; i < 5000; i++) begin
      tick(1);
      irst_n = ($urandom_range(0, 599) != 0);
      if ($urandom_range(0, 59) == 0) ilock = ~ilock;
    end

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Sits directly downstream of the debounced board reset.
- Takes the clean, synchronous active-low reset and the clock-generator lock indication.
- Releases NUM_STAGES reset outputs one at a time, in order from stage 0 upward, with a fixed gap between releases.
- Signals completion, and signals a fault if lock never arrives.

Parameters:
- NUM_STAGES, 4: number of sequenced reset outputs; must be at least 1.
- STAGE_DELAY, 16: clock cycles between successive stage releases; must be at least 1.
- LOCK_TIMEOUT, 200: cycles allowed in WaitLock before declaring a fault; must be at least 1.
- CNT_W, 8: counter width; must hold max(STAGE_DELAY, LOCK_TIMEOUT)-1.

Ports:
- iclk  input  1  clock.
- irst_n  input  1  reset, synchronous, active-low; clock iclk. Driven by the debounced reset.
- ilock  input  1  clock-generator lock, asynchronous to iclk; resynchronised internally.
- orst_n  output  NUM_STAGES  per-stage active-low reset; bit 0 is released first.
- odone  output  1  high once all stages are released.
- otimeout  output  1  high while in the Fault state.

Behaviour:
- Reset (irst_n=0 at a rising edge):
  - orst_n=all 0, odone=0, otimeout=0.
  - counter=0, stage index=0, state Hold.
  - Lock synchroniser flops cleared to 0.
  - Reset has priority over every other event in every state.
- Lock synchroniser: two flops; ilock_s follows ilock with 2 cycles of latency.
- States:
  - Hold: entered only through reset. Leaves for WaitLock on the first edge with irst_n=1. counter=0.
  - WaitLock: counter increments each cycle.
    - ilock_s=1: go to Release, counter=0, index=0.
    - Otherwise, counter==LOCK_TIMEOUT-1: go to Fault, otimeout=1.
    - Lock wins if both happen on the same cycle.
  - Release: counter increments each cycle.
    - When counter==STAGE_DELAY-1: orst_n[index]<=1, counter=0, index++.
    - When index==NUM_STAGES-1 is released: go to Done and set odone=1 on the same edge.
    - Stage k therefore rises (k+1)*STAGE_DELAY cycles after Release entry.
  - Done: outputs held; counter idle.
  - Fault: orst_n stays all 0, otimeout=1. Without the optional feature this is terminal until irst_n=0.
- Lock loss: ilock_s=0 in Release or Done causes, on the next edge:
  - orst_n=all 0, odone=0, counter=0, index=0, state WaitLock.
  - A fresh timeout window begins.
- orst_n assertion is simultaneous on all bits; release is strictly ordered. Bit k is never 1 while bit k-1 is 0.
- All outputs are registered. No combinational path from any input to any output.
- Illegal state encoding: go to Hold, with outputs as for reset.

Optional Feature:
- Macro: RSTSEQ_AUTO_RETRY_EN.
- Defined:
  - Fault counts LOCK_TIMEOUT cycles, then returns to WaitLock with counter=0 and otimeout=0.
  - If ilock_s=1 during Fault, go to WaitLock immediately on the next edge.
- Undefined: Fault holds until irst_n=0; the retry logic is absent.

Decomposition:
- Package rst_seq_pkg holds:
  - state encodings: Hold, WaitLock, Release, Done, Fault, one-hot or 3-bit binary;
  - the synchroniser depth constant (2).
- One sub-module, bit_synchronizer: a 2-flop synchroniser with synchronous active-low clear, instantiated for ilock.
- Everything else is in one always block plus output registers.

Test Plan:
All scenarios use defaults NUM_STAGES=4, STAGE_DELAY=16, LOCK_TIMEOUT=200.
- Power-up, ilock=1: irst_n=0 for 5 cycles, then 1.
  - orst_n=0000 throughout reset.
  - Release entered after sync latency.
  - orst_n becomes 0001 at +16, 0011 at +32, 0111 at +48, 1111 at +64 cycles.
  - odone=1 on the same edge as 1111.
- ilock held 0 after reset release: otimeout=1 exactly 200 cycles after WaitLock entry; orst_n stays 0000; odone=0.
- Lock loss in Done (1111) by dropping ilock: 3 edges later orst_n=0000 and odone=0. Re-raising ilock repeats the 16/32/48/64 release sequence.
- irst_n=0 while orst_n=0011: next edge gives orst_n=0000, state Hold, odone=0, otimeout=0.
- ilock_s rises on the same cycle as counter==199 in WaitLock: Release is entered and otimeout stays 0.
- With RSTSEQ_AUTO_RETRY_EN: ilock=0 for 200 cycles gives otimeout=1. After 200 more cycles otimeout=0. ilock=1 then gives the normal release sequence with odone=1.
